// File: rtl/register_file_if.sv
// register_file_if: decode/writeback side of the register file (addresses, write data, read operands)
interface register_file_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  regWrite;
   logic [ADDR_WIDTH-1:0] RD1;
   logic [ADDR_WIDTH-1:0] RD2;
   logic [ADDR_WIDTH-1:0] writeReg;
   logic [DATA_WIDTH-1:0] writeData;
   logic [DATA_WIDTH-1:0] readData1;
   logic [DATA_WIDTH-1:0] readData2;
   modport master (
      output regWrite, RD1, RD2, writeReg, writeData,
      input  readData1, readData2
   );
   modport slave (
      input  regWrite, RD1, RD2, writeReg, writeData,
      output readData1, readData2
   );
endinterface

// File: rtl/register_file.sv
// register_file: 32x32 GPR file, two combinational read ports, one synchronous write port, x0 hardwired to zero
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input logic           clk,
   input logic           reset,
   register_file_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];
   always_comb begin
      regs_d = regs_q;
      if (bus.regWrite && bus.writeReg != '0) regs_d[bus.writeReg] = bus.writeData;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) regs_q <= '{default: '0};
      else        regs_q <= regs_d;
   end
   // x0 is gated on the read side too, so it never depends on storage contents
   assign bus.readData1 = (bus.RD1 == '0) ? '0 : regs_q[bus.RD1];
   assign bus.readData2 = (bus.RD2 == '0) ? '0 : regs_q[bus.RD2];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and randomized checks of register_file against an array reference model
module tb_register_file;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] model [32];
   register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
   register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   task automatic tick();
      if (reset && bus.regWrite && bus.writeReg != 5'd0) model[bus.writeReg] = bus.writeData;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      bus.writeReg = a; bus.writeData = d; bus.regWrite = 1'b1;
      tick();
      bus.regWrite = 1'b0;
   endtask

   task automatic test_reset();
      bus.regWrite = 1'b0; bus.writeReg = 5'd0; bus.writeData = 32'h0;
      bus.RD1 = 5'd0; bus.RD2 = 5'd0;
      clear_model();
      for (int i = 0; i < 32; i++) begin
         bus.RD1 = 5'(i); bus.RD2 = 5'(31 - i); #1;
         n_cmp++;
         if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
            n_bad++; $display("FAIL reset_state addr %0d: rd1=%h rd2=%h required 0", i, bus.readData1, bus.readData2);
         end
      end
      @(negedge clk); reset = 1'b1; #1;
      tick();
      do_write(5'd1, 32'h1111_0001); do_write(5'd15, 32'h1111_000F); do_write(5'd31, 32'h1111_001F);
      #2; reset = 1'b0; clear_model(); #1;
      for (int k = 0; k < 3; k++) begin
         bus.RD1 = (k == 0) ? 5'd1 : (k == 1) ? 5'd15 : 5'd31; bus.RD2 = bus.RD1; #1;
         n_cmp++;
         if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
            n_bad++; $display("FAIL async_reset addr %0d: rd1=%h rd2=%h required 0", bus.RD1, bus.readData1, bus.readData2);
         end
      end
      @(negedge clk); reset = 1'b1; #1;
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         bus.RD1 = (k == 0) ? 5'd1 : (k == 1) ? 5'd15 : 5'd31; bus.RD2 = bus.RD1; #1;
         n_cmp++;
         if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
            n_bad++; $display("FAIL post_reset addr %0d: rd1=%h rd2=%h required 0", bus.RD1, bus.readData1, bus.readData2);
         end
      end
   endtask

   task automatic test_basic();
      do_write(5'd1, 32'hDEAD_BEEF);
      bus.RD1 = 5'd1; bus.RD2 = 5'd1; #1;
      n_cmp++;
      if (bus.readData1 !== 32'hDEAD_BEEF || bus.readData2 !== 32'hDEAD_BEEF) begin
         n_bad++; $display("FAIL basic_rw: rd1=%h rd2=%h required deadbeef", bus.readData1, bus.readData2);
      end
      for (int i = 2; i < 32; i++) begin
         bus.RD1 = 5'(i); bus.RD2 = 5'(i); #1;
         n_cmp++;
         if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
            n_bad++; $display("FAIL basic_others addr %0d: rd1=%h rd2=%h required 0", i, bus.readData1, bus.readData2);
         end
      end
   endtask

   task automatic test_we_off();
      bus.regWrite = 1'b0; bus.writeReg = 5'd2; bus.writeData = 32'h1234_5678;
      tick(); tick(); tick();
      bus.RD1 = 5'd2; bus.RD2 = 5'd2; #1;
      n_cmp++;
      if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
         n_bad++; $display("FAIL we_off: rd1=%h rd2=%h required 0", bus.readData1, bus.readData2);
      end
   endtask

   task automatic test_x0();
      bus.RD1 = 5'd0; bus.RD2 = 5'd0;
      bus.writeReg = 5'd0; bus.writeData = 32'hFFFF_FFFF; bus.regWrite = 1'b1; #1;
      n_cmp++;
      if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
         n_bad++; $display("FAIL x0_pre_edge: rd1=%h rd2=%h required 0", bus.readData1, bus.readData2);
      end
      tick();
      bus.regWrite = 1'b0; #1;
      n_cmp++;
      if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
         n_bad++; $display("FAIL x0_hardwire: rd1=%h rd2=%h required 0", bus.readData1, bus.readData2);
      end
   endtask

   task automatic test_sweep();
      logic [31:0] e1, e2;
      for (int i = 1; i < 32; i++) do_write(5'(i), 32'hA5A5_0000 | 32'(i));
      for (int i = 0; i < 32; i++) begin
         bus.RD1 = 5'(i); bus.RD2 = 5'(31 - i); #1;
         e1 = (i == 0) ? 32'h0 : (32'hA5A5_0000 | 32'(i));
         e2 = (i == 31) ? 32'h0 : (32'hA5A5_0000 | 32'(31 - i));
         n_cmp++;
         if (bus.readData1 !== e1 || bus.readData2 !== e2) begin
            n_bad++; $display("FAIL sweep i=%0d: rd1=%h rd2=%h required %h %h", i, bus.readData1, bus.readData2, e1, e2);
         end
      end
   endtask

   task automatic test_read_during_write();
      do_write(5'd5, 32'h1111_1111);
      bus.writeReg = 5'd5; bus.writeData = 32'h2222_2222; bus.regWrite = 1'b1; bus.RD1 = 5'd5; bus.RD2 = 5'd5; #1;
      n_cmp++;
      if (bus.readData1 !== 32'h1111_1111 || bus.readData2 !== 32'h1111_1111) begin
         n_bad++; $display("FAIL rdw_old: rd1=%h rd2=%h required 11111111", bus.readData1, bus.readData2);
      end
      tick();
      n_cmp++;
      if (bus.readData1 !== 32'h2222_2222 || bus.readData2 !== 32'h2222_2222) begin
         n_bad++; $display("FAIL rdw_new: rd1=%h rd2=%h required 22222222", bus.readData1, bus.readData2);
      end
      bus.writeData = 32'h3333_3333; #2;
      reset = 1'b0; clear_model(); #1;
      n_cmp++;
      if (bus.readData1 !== 32'h0) begin
         n_bad++; $display("FAIL rdw_reset_async: rd1=%h required 0", bus.readData1);
      end
      tick();
      n_cmp++;
      if (bus.readData1 !== 32'h0) begin
         n_bad++; $display("FAIL rdw_reset_blocks_write: rd1=%h required 0", bus.readData1);
      end
      bus.regWrite = 1'b0; @(negedge clk); reset = 1'b1; tick();
      n_cmp++;
      if (bus.readData1 !== 32'h0) begin
         n_bad++; $display("FAIL rdw_after_reset: rd1=%h required 0", bus.readData1);
      end
      bus.writeReg = 5'd7; bus.writeData = 32'h7777_7777; bus.regWrite = 1'b1; bus.RD1 = 5'd7;
      tick();
      bus.regWrite = 1'b0; #1;
      n_cmp++;
      if (bus.readData1 !== 32'h7777_7777) begin
         n_bad++; $display("FAIL first_write_after_reset: rd1=%h required 77777777", bus.readData1);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         bus.regWrite = ($urandom_range(0, 3) != 0);
         bus.writeReg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         bus.writeData = $urandom;
         bus.RD1 = ($urandom_range(0, 3) == 0) ? bus.writeReg : 5'($urandom);
         bus.RD2 = ($urandom_range(0, 3) == 0) ? bus.RD1 : 5'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b0; clear_model();
         end
         #1;
         n_cmp++;
         if (bus.readData1 !== model[bus.RD1] || bus.readData2 !== model[bus.RD2]) begin
            n_bad++; $display("FAIL random n=%0d addr %0d/%0d: rd=%h/%h required %h/%h", n, bus.RD1, bus.RD2,
                              bus.readData1, bus.readData2, model[bus.RD1], model[bus.RD2]);
         end
         tick();
         n_cmp++;
         if (bus.readData1 !== model[bus.RD1] || bus.readData2 !== model[bus.RD2]) begin
            n_bad++; $display("FAIL random_post n=%0d addr %0d/%0d: rd=%h/%h required %h/%h", n, bus.RD1, bus.RD2,
                              bus.readData1, bus.readData2, model[bus.RD1], model[bus.RD2]);
         end
         reset = 1'b1;
      end
      bus.regWrite = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_we_off();
      test_x0();
      test_sweep();
      test_read_during_write();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
